// File: rtl/sigmoid_pwl_seq_pkg.sv
// -----------------------------------------------------------------------------
// sigmoid_pwl_pkg
// Shared constants for the piecewise-linear sigmoid sequencer:
//   - Q8.8 format defaults and the ONE constant
//   - breakpoint / intercept / slope coefficient tables (Q8.8, unsigned)
//   - the sequencer state encoding
//   - small ROM lookup helpers that never index past the table end
// -----------------------------------------------------------------------------
package sigmoid_pwl_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 8;
    localparam int NUM_SEG    = 6;
    localparam int SEG_W      = 3;
    localparam int SLOPE_W    = 8;
    localparam int PROD_W     = 24;

    localparam logic [15:0] ONE = 16'd256;

    // Segment start points over |x|: 0,1,2,3,4,5 in real units.
    localparam logic [15:0] BP [NUM_SEG] = '{16'd0, 16'd256, 16'd512,
                                             16'd768, 16'd1024, 16'd1280};
    localparam logic [15:0] ICPT [NUM_SEG] = '{16'd128, 16'd187, 16'd225,
                                               16'd244, 16'd251, 16'd254};
    // The last segment is flat so the result pins at 254 for |x| >= 5.
    localparam logic [SLOPE_W-1:0] SLOPE [NUM_SEG] = '{8'd59, 8'd38, 8'd19,
                                                       8'd7, 8'd3, 8'd0};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ABS  = 3'd1,
        SEG  = 3'd2,
        MUL  = 3'd3,
        ADD  = 3'd4,
        SYM  = 3'd5,
        OUT  = 3'd6
    } state_e;

    // Breakpoint lookup; unused segment codes fall back to the flat segment.
    function automatic logic [15:0] bp_of(input logic [SEG_W-1:0] seg);
        case (seg)
            3'd0:    bp_of = BP[0];
            3'd1:    bp_of = BP[1];
            3'd2:    bp_of = BP[2];
            3'd3:    bp_of = BP[3];
            3'd4:    bp_of = BP[4];
            3'd5:    bp_of = BP[5];
            default: bp_of = BP[NUM_SEG-1];
        endcase
    endfunction

    // Intercept lookup; unused segment codes fall back to the flat segment.
    function automatic logic [15:0] icpt_of(input logic [SEG_W-1:0] seg);
        case (seg)
            3'd0:    icpt_of = ICPT[0];
            3'd1:    icpt_of = ICPT[1];
            3'd2:    icpt_of = ICPT[2];
            3'd3:    icpt_of = ICPT[3];
            3'd4:    icpt_of = ICPT[4];
            3'd5:    icpt_of = ICPT[5];
            default: icpt_of = ICPT[NUM_SEG-1];
        endcase
    endfunction

    // Slope lookup; unused segment codes fall back to the flat segment.
    function automatic logic [SLOPE_W-1:0] slope_of(input logic [SEG_W-1:0] seg);
        case (seg)
            3'd0:    slope_of = SLOPE[0];
            3'd1:    slope_of = SLOPE[1];
            3'd2:    slope_of = SLOPE[2];
            3'd3:    slope_of = SLOPE[3];
            3'd4:    slope_of = SLOPE[4];
            3'd5:    slope_of = SLOPE[5];
            default: slope_of = SLOPE[NUM_SEG-1];
        endcase
    endfunction

endpackage

// File: rtl/sigmoid_pwl_seq_seg_select.sv
// -----------------------------------------------------------------------------
// pwl_seg_select
// Combinational segment selection for the PWL sigmoid.
//   ax_i    : |x| in Q8.8 (unsigned, at most 0x7FFF)
//   seg_o   : segment index, min(integer part of |x|, NUM_SEG-1)
//   off_o   : |x| minus the segment breakpoint (0..255 for segments 0..4)
//   slope_o : slope coefficient of the selected segment
//   icpt_o  : intercept coefficient of the selected segment
// The parent registers all outputs in its SEG state.
// -----------------------------------------------------------------------------
module pwl_seg_select
    import sigmoid_pwl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic [DATA_W-1:0]  ax_i,
    output logic [SEG_W-1:0]   seg_o,
    output logic [DATA_W-1:0]  off_o,
    output logic [SLOPE_W-1:0] slope_o,
    output logic [DATA_W-1:0]  icpt_o
);

    logic [DATA_W-FRAC_W-1:0] int_part_s;
    logic [SEG_W-1:0]         seg_s;

    // Segment index, offset into the segment and coefficient lookup.
    always_comb begin
        int_part_s = ax_i[DATA_W-1:FRAC_W];
        // An exact breakpoint has a zero fractional part, so it lands in the upper segment.
        if (int_part_s >= (DATA_W-FRAC_W)'(NUM_SEG-1)) begin
            seg_s = SEG_W'(NUM_SEG-1);
        end else begin
            seg_s = int_part_s[SEG_W-1:0];
        end
        seg_o   = seg_s;
        off_o   = ax_i - bp_of(seg_s);
        slope_o = slope_of(seg_s);
        icpt_o  = icpt_of(seg_s);
    end

endmodule

// File: rtl/sigmoid_pwl_seq.sv
// -----------------------------------------------------------------------------
// sigmoid_pwl_seq
// Multi-cycle sequencer computing sigmoid(x) with a 6-segment PWL
// approximation over |x| and the symmetry sigmoid(-x) = 1 - sigmoid(x).
// One sample in flight; the output is valid 5 cycles after the accept edge.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   in_valid   : sample valid          in_ready  : accepting a sample (IDLE)
//   in_data    : signed Q8.8 sample
//   out_valid  : result valid          out_ready : downstream takes result
//   out_data   : sigmoid(x), Q8.8, 0..256, zero-extended
//   busy       : sequencer not in IDLE
// -----------------------------------------------------------------------------
module sigmoid_pwl_seq
    import sigmoid_pwl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    state_e               state_q, state_d;
    logic [DATA_W-1:0]    x_q, x_d;
    logic                 sign_q, sign_d;
    logic [DATA_W-1:0]    ax_q, ax_d;
    logic [SEG_W-1:0]     seg_q, seg_d;
    logic [DATA_W-1:0]    off_q, off_d;
    logic [SLOPE_W-1:0]   slope_q, slope_d;
    logic [DATA_W-1:0]    icpt_q, icpt_d;
    logic [PROD_W-1:0]    prod_q, prod_d;
    logic [DATA_W-1:0]    y_q, y_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic [SEG_W-1:0]     seg_s;
    logic [DATA_W-1:0]    off_s;
    logic [SLOPE_W-1:0]   slope_s;
    logic [DATA_W-1:0]    icpt_s;
    logic [PROD_W-1:0]    rnd_s;
    logic [DATA_W:0]      sum_s;

    pwl_seg_select #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_seg_select (
        .ax_i    (ax_q),
        .seg_o   (seg_s),
        .off_o   (off_s),
        .slope_o (slope_s),
        .icpt_o  (icpt_s)
    );

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            sign_q      <= 1'b0;
            ax_q        <= '0;
            seg_q       <= '0;
            off_q       <= '0;
            slope_q     <= '0;
            icpt_q      <= '0;
            prod_q      <= '0;
            y_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            sign_q      <= sign_d;
            ax_q        <= ax_d;
            seg_q       <= seg_d;
            off_q       <= off_d;
            slope_q     <= slope_d;
            icpt_q      <= icpt_d;
            prod_q      <= prod_d;
            y_q         <= y_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and datapath step for each sequencer state.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        sign_d  = sign_q;
        ax_d    = ax_q;
        seg_d   = seg_q;
        off_d   = off_q;
        slope_d = slope_q;
        icpt_d  = icpt_q;
        prod_d  = prod_q;
        y_d     = y_q;
        // Round half up before dropping the fractional bits of the product.
        rnd_s   = (prod_q + PROD_W'(1 << (FRAC_W-1))) >> FRAC_W;
        sum_s   = (DATA_W+1)'(icpt_q) + (DATA_W+1)'(rnd_s);

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    x_d     = in_data;
                    state_d = ABS;
                end else begin
                    state_d = IDLE;
                end
            end
            ABS: begin
                sign_d = x_q[DATA_W-1];
                // The most negative value has no positive twin; clamp it to max.
                if (x_q == {1'b1, {(DATA_W-1){1'b0}}}) begin
                    ax_d = {1'b0, {(DATA_W-1){1'b1}}};
                end else if (x_q[DATA_W-1]) begin
                    ax_d = ~x_q + DATA_W'(1);
                end else begin
                    ax_d = x_q;
                end
                state_d = SEG;
            end
            SEG: begin
                seg_d   = seg_s;
                off_d   = off_s;
                slope_d = slope_s;
                icpt_d  = icpt_s;
                state_d = MUL;
            end
            MUL: begin
                prod_d  = PROD_W'(slope_q) * PROD_W'(off_q);
                state_d = ADD;
            end
            ADD: begin
                if (sum_s > (DATA_W+1)'(ONE)) begin
                    y_d = DATA_W'(ONE);
                end else begin
                    y_d = sum_s[DATA_W-1:0];
                end
                state_d = SYM;
            end
            SYM: begin
                if (sign_q) begin
                    y_d = DATA_W'(ONE) - y_q;
                end else begin
                    y_d = y_q;
                end
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags follow the upcoming state so they are registered outputs.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == OUT);
        busy_d      = (state_d != IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = y_q;

endmodule

// File: tb/tb_sigmoid_pwl_seq.sv
// -----------------------------------------------------------------------------
// tb_sigmoid_pwl_seq
// Directed and randomized bench for sigmoid_pwl_seq with a behavioural
// sigmoid PWL reference computed by plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_sigmoid_pwl_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    int icpt_t  [6] = '{128, 187, 225, 244, 251, 254};
    int slope_t [6] = '{59, 38, 19, 7, 3, 0};

    sigmoid_pwl_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: sigmoid(x) from the real-valued PWL description, in integers.
    function automatic logic [15:0] ref_sig(input logic [15:0] x);
        int xi, ax, seg, off, y;
        xi = int'($signed(x));
        ax = (xi < 0) ? -xi : xi;
        if (ax > 32767) ax = 32767;
        seg = ax / 256;
        if (seg > 5) seg = 5;
        off = ax - seg * 256;
        y = icpt_t[seg] + (slope_t[seg] * off + 128) / 256;
        if (y > 256) y = 256;
        if (xi < 0) y = 256 - y;
        return 16'(y);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, latency, optional output stall, handshake.
    task automatic run_sample(input logic [15:0] x, input logic [15:0] exp,
                              input int stall, input string tag);
        int   lat;
        logic busy_ok;
        lat = 0;
        while (in_ready !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        check({tag, "_rdy_low"}, 32'(in_ready), 32'd0);
        lat     = 0;
        busy_ok = 1'b1;
        while (out_valid !== 1'b1 && lat < 12) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd5);
        check({tag, "_busy"}, 32'(busy_ok), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            // Traffic on the input side must be ignored while a result waits.
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            @(posedge clk); #1;
            check({tag, "_hold_v"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_d"}, 32'(out_data), 32'(exp));
            check({tag, "_hold_r"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drop_v"}, 32'(out_valid), 32'd0);
        check({tag, "_back_r"}, 32'(in_ready), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] x;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 16'd0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed points, expected values written from the coefficient table.
        run_sample(16'h0000, 16'd128, 0, "zero");
        run_sample(16'h0080, 16'd158, 0, "half");
        run_sample(16'h0100, 16'd187, 0, "one");
        run_sample(16'hFF00, 16'd69,  0, "neg_one");
        run_sample(16'h8000, 16'd2,   0, "most_neg");
        run_sample(16'h0A00, 16'd254, 4, "ten_stall");
        run_sample(16'h0500, 16'd254, 0, "bp5");
        run_sample(16'hFB00, 16'd2,   1, "neg_bp5");
        run_sample(16'h01FF, 16'd225, 0, "seg1_top");
        run_sample(16'h7FFF, 16'd254, 0, "max_pos");

        // Asynchronous reset while the sample is in the multiply step.
        in_valid = 1'b1;
        in_data  = 16'h0100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("arst_no_result", 32'(out_valid), 32'd0);
        run_sample(16'h0100, 16'd187, 0, "post_rst");

        // Random stream against the reference with random output stalls.
        for (int n = 0; n < 8; n++) begin
            r = $urandom;
            if (r[0]) x = r[31:16];
            else      x = 16'($urandom_range(0, 1535));
            if (r[1] && !r[0]) x = ~x + 16'd1;
            run_sample(x, ref_sig(x), int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sigmoid_pwl_seq.md
Name: sigmoid_pwl_seq

Overview:
- Multi-cycle sequencer for the piecewise-linear sigmoid approximator in the VAE activation path.
- Accepts one signed Q8.8 sample per transaction on a valid/ready input.
- Steps the sample through abs/segment-select, offset subtraction, a single shared multiply, intercept add and symmetry fold.
- Returns sigmoid(x) in Q8.8 on a valid/ready output; one sample in flight, fixed latency, no pipelining across samples.

Parameters:
- DATA_W, 16, sample/result width (signed in, unsigned result in range 0..256).
- FRAC_W, 8, fractional bits of the Q format.
- NUM_SEG, 6, number of PWL segments over |x|. Breakpoints are 0,1,2,3,4,5 in real units; the last segment is flat.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  DATA_W  signed Q8.8 sample x
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_W  sigmoid(x), Q8.8, zero-extended, range 0..256
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0 except in_ready=1. FSM goes to IDLE and all internal registers clear. Reset mid-operation discards the sample in flight; no partial result is ever emitted.
- FSM states and transitions: IDLE -> ABS -> SEG -> MUL -> ADD -> SYM -> OUT -> IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready, register x and go to ABS.
  - ABS: sign <= x[15]; ax <= |x|. -32768 saturates to 0x7FFF.
  - SEG: seg <= min(ax>>FRAC_W, NUM_SEG-1); off <= ax - BP[seg], 16-bit unsigned. For seg 0..4, off lies in 0..255.
  - MUL: prod <= SLOPE[seg] * off. Unsigned; 8b x 16b = 24b product, registered.
  - ADD: y <= ICPT[seg] + ((prod + 128) >> 8), round half up, then saturate to 256.
  - SYM: if sign, y <= 256 - y.
  - OUT: out_valid=1, out_data=y. Hold data stable while out_ready=0. On out_ready, go to IDLE in the next cycle and drop out_valid.
- Latency: input accept edge = cycle 0; out_valid rises at cycle 5 after the accept edge. With out_ready held high, the next accept is possible at cycle 7.
- in_ready=0 in every non-IDLE state; in_valid is ignored there.
- Coefficient ROM, Q8.8 unsigned:
  - ICPT = {128, 187, 225, 244, 251, 254}
  - SLOPE = {59, 38, 19, 7, 3, 0}
- Boundaries:
  - Exact breakpoint inputs select the upper segment with off=0.
  - |x| >= 5.0 selects seg 5: result 254, or 2 for negative x.
  - Output is never below 0 or above 256.
- out_valid and in_ready are never high in the same cycle.

Decomposition:
- Package sigmoid_pwl_pkg holds:
  - DATA_W/FRAC_W defaults and the Q8.8 ONE constant (256).
  - BP, ICPT and SLOPE constant arrays.
  - The FSM state enum, 3 bits: IDLE, ABS, SEG, MUL, ADD, SYM, OUT.
- One sub-module, pwl_seg_select: combinational segment index plus offset subtraction. Inputs: ax. Outputs: seg, off, slope, icpt. It is registered by the parent in SEG.

Test Plan:
- x=0x0000 -> out_data=0x0080 (128), out_valid exactly 5 cycles after accept, busy high throughout.
- x=0x0080 (0.5) -> seg0, off=128, 59*128+128>>8=30 -> 0x009E (158); x=0x0100 (1.0) -> 0x00BB (187).
- x=0xFF00 (-1.0) -> 256-187 = 0x0045 (69); x=0x8000 -> |x| saturates to 0x7FFF, seg5 -> 0x0002.
- x=0x0A00 (10.0) -> 0x00FE (254). Hold out_ready=0 for 4 cycles: out_data is stable and in_ready stays 0. Release: in_ready returns one cycle after the handshake.
- Assert rst asynchronously during MUL -> outputs clear immediately with no clock edge and in_ready=1. Next sample 0x0100 returns 187 with normal latency.
- Back-to-back stream of 8 random samples with random out_ready stalls -> every result matches the reference model and no sample is dropped or duplicated.
